// File: rtl/proc_n_if.sv
// proc_n_if: groups the run/instruction/debug signals of the proc_n bus processor.
// Latency: wiring only. Backpressure: none; the master holds Run/DIN, Busy tells it when an instruction is in flight.
// Signals (named from the processor's side): i_run start request, i_din instruction/immediate,
//   o_done last cycle of an instruction, o_busy not in T0, o_bus_wires internal bus value,
//   i_reg_sel debug register index, o_reg_out combinational read of R[i_reg_sel].
interface proc_n_if #(
  parameter int DW   = 16,
  parameter int NREG = 8
);
  localparam int RW = $clog2(NREG);

  logic          i_run;
  logic [DW-1:0] i_din;
  logic          o_done;
  logic          o_busy;
  logic [DW-1:0] o_bus_wires;
  logic [RW-1:0] i_reg_sel;
  logic [DW-1:0] o_reg_out;

  // master drives the processor (testbench / board logic)
  modport master (
    output i_run, i_din, i_reg_sel,
    input  o_done, o_busy, o_bus_wires, o_reg_out
  );

  // slave is the processor itself
  modport slave (
    input  i_run, i_din, i_reg_sel,
    output o_done, o_busy, o_bus_wires, o_reg_out
  );
endinterface

// File: rtl/proc_n.sv
// proc_n: multi-cycle single-bus processor (mv/mvi/add/sub/and/or/xor/mvnz) with NREG x DW registers.
// Latency: mv/mvi/mvnz take 2 cycles (T0,T1), ALU ops take 4 (T0..T3); next instruction accepted right after Done.
// Backpressure: Run is only sampled in T0; Busy high means any Run request is ignored.
// Ports: i_clk clock, i_reset synchronous active-high reset, cpu (proc_n_if.slave) carries
//   Run, DIN, Done, Busy, BusWires, RegSel and RegOut.
module proc_n #(
  parameter int DW   = 16,   // must satisfy DW >= 3 + 2*RW so an instruction fits in DIN
  parameter int NREG = 8     // power of two, 2..16
) (
  input  logic     i_clk,
  input  logic     i_reset,
  proc_n_if.slave  cpu
);
  localparam int RW  = $clog2(NREG);
  localparam int IRW = 2 * RW + 3;   // only op/X/Y are kept; upper DIN bits are don't-care

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_MVNZ = 3'b111;

  typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

  state_t         r_state;
  logic [IRW-1:0] r_ir;
  logic [DW-1:0]  r_regs [NREG];
  logic [DW-1:0]  r_a;
  logic [DW-1:0]  r_g;

  logic [2:0]     w_op;
  logic [RW-1:0]  w_x;
  logic [RW-1:0]  w_y;
  logic [DW-1:0]  w_bus;
  logic [DW-1:0]  w_alu;
  logic           w_done;
  logic           w_short_op;

  assign w_op = r_ir[2*RW+2 -: 3];
  assign w_x  = r_ir[2*RW-1 -: RW];
  assign w_y  = r_ir[RW-1:0];

  // mv/mvi/mvnz finish in T1; everything else goes through the ALU path
  assign w_short_op = (w_op == OP_MV) || (w_op == OP_MVI) || (w_op == OP_MVNZ);

  // Single shared bus: exactly one source per state, zero when idle
  always_comb begin
    w_bus = '0;
    case (r_state)
      T1: begin
        case (w_op)
          OP_MVI:         w_bus = cpu.i_din;
          OP_MV, OP_MVNZ: w_bus = r_regs[w_y];
          default:        w_bus = r_regs[w_x];  // ALU ops load A with R[X]
        endcase
      end
      T2:      w_bus = r_regs[w_y];
      T3:      w_bus = r_g;
      default: w_bus = '0;
    endcase
  end

  // Second operand comes straight off the bus in T2; add/sub wrap modulo 2^DW
  always_comb begin
    w_alu = '0;
    case (w_op)
      OP_ADD:  w_alu = r_a + w_bus;
      OP_SUB:  w_alu = r_a - w_bus;
      OP_AND:  w_alu = r_a & w_bus;
      OP_OR:   w_alu = r_a | w_bus;
      OP_XOR:  w_alu = r_a ^ w_bus;
      default: w_alu = '0;
    endcase
  end

  assign w_done = ((r_state == T1) && w_short_op) || (r_state == T3);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= T0;
      r_ir    <= '0;
      r_a     <= '0;
      r_g     <= '0;
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      case (r_state)
        T0: begin
          if (cpu.i_run) begin
            r_ir    <= cpu.i_din[IRW-1:0];
            r_state <= T1;
          end
        end
        T1: begin
          case (w_op)
            OP_MV, OP_MVI: begin
              r_regs[w_x] <= w_bus;
              r_state     <= T0;
            end
            OP_MVNZ: begin
              // G holds the last ALU result; write is suppressed when it is zero
              if (r_g != '0) begin
                r_regs[w_x] <= w_bus;
              end
              r_state <= T0;
            end
            default: begin
              r_a     <= w_bus;
              r_state <= T2;
            end
          endcase
        end
        T2: begin
          r_g     <= w_alu;
          r_state <= T3;
        end
        T3: begin
          r_regs[w_x] <= w_bus;
          r_state     <= T0;
        end
        default: r_state <= T0;
      endcase
    end
  end

  assign cpu.o_done      = w_done;
  assign cpu.o_busy      = (r_state != T0);
  assign cpu.o_bus_wires = w_bus;
  assign cpu.o_reg_out   = r_regs[cpu.i_reg_sel];

endmodule

// File: doc/proc_n.md
Name: proc_n

Overview:
- Parametrised successor to the team's 8-bit multi-cycle bus processor.
- Generalised in data width and register-file depth; the instruction set grows from mv/mvi/add/sub to eight opcodes, adding and/or/xor and a conditional move (mvnz).
- Instructions and immediates arrive on DIN. One shared internal bus moves data between registers, DIN, ALU operand register A and result register G.
- A debug read port drives the board's HEX displays from any register.

Parameters:
- DW, 16: data/bus width in bits. Must satisfy DW >= 3 + 2*RW.
- NREG, 8: number of general registers. Power of two, 2..16.
- RW, $clog2(NREG): register-index width. Derived; not to be overridden.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Run  in  1  start request; sampled only in state T0.
- DIN  in  DW  instruction word in T0; immediate value in T1 of mvi.
- Done  out  1  high during the final cycle of each instruction.
- Busy  out  1  high in any state other than T0.
- BusWires  out  DW  current value on the internal bus.
- RegSel  in  RW  debug register index.
- RegOut  out  DW  combinational read of R[RegSel].

Behaviour:
- Reset: when Reset=1 at a rising edge, all R[i], A, G and IR go to 0 and the state goes to T0. Afterwards Done=0, Busy=0, BusWires=0. Reset overrides any in-flight instruction; a partial result is never written.
- Instruction decode from IR:
  - op = IR[2RW+2:2RW]
  - X = IR[2RW-1:RW]
  - Y = IR[RW-1:0]
  - IR bits above 2RW+2 are ignored.
- Opcodes: 000 mv, 001 mvi, 010 add, 011 sub, 100 and, 101 or, 110 xor, 111 mvnz.
- States: T0, T1, T2, T3 (one-hot or binary, implementer's choice).
- T0:
  - Bus = 0.
  - If Run=1: IR <= DIN, go to T1. Otherwise stay in T0.
  - Run is ignored in every other state.
- T1:
  - mv: bus = R[Y]; R[X] <= bus; Done=1; go to T0.
  - mvi: bus = DIN; R[X] <= bus; Done=1; go to T0.
  - mvnz: bus = R[Y]; R[X] <= bus only if G != 0; Done=1 regardless; go to T0. G is unchanged.
  - ALU ops (add/sub/and/or/xor): bus = R[X]; A <= bus; go to T2.
- T2 (ALU ops only): bus = R[Y]; G <= A op bus; go to T3.
  - add/sub are modulo 2^DW; carry/borrow is discarded.
  - sub computes A - R[Y].
- T3 (ALU ops only): bus = G; R[X] <= bus; Done=1; go to T0.
- Latency:
  - mv, mvi, mvnz: 2 cycles including T0.
  - ALU ops: 4 cycles.
  - A new instruction may be accepted in the cycle immediately after Done.
- X == Y is legal:
  - add R2,R2 doubles R2.
  - sub Rx,Rx gives 0.
  - mv Rx,Rx is a no-op write.
- Only one register is written per cycle. No register is written in T0 or T2.
- Done, Busy and BusWires are combinational from state and IR; they must be glitch-free at the sampling edge only.
- RegOut is purely combinational and reflects register writes in the cycle after the edge.

Test Plan (DW=16, NREG=8; op bits [8:6], X bits [5:3], Y bits [2:0]):
- Reset: pulse Reset for one cycle after random writes -> R0..R7=0, G=0, Done=0, Busy=0, BusWires=0; RegOut=0 for every RegSel.
- mvi then mv:
  - Run=1, DIN=0x0040, then DIN=0x0005 in T1 -> BusWires=0x0005 and Done=1 in the 2nd cycle; R0=5 afterwards.
  - Then DIN=0x0008 (mv R1,R0) -> R1=5 after 2 cycles.
- add:
  - With R0=5, R1=5, issue DIN=0x0081 (add R0,R1).
  - Done is high only in cycle 4; BusWires is 5, 5, 10 across T1..T3; R0=10 afterwards.
- sub wrap:
  - With R2=0, R3=1, issue DIN=0x00D3 (sub R2,R3) -> R2=0xFFFF.
  - Then xor R2,R2 (DIN=0x0192) -> R2=0.
- mvnz:
  - With G=0, R4=7, R5=9: DIN=0x01E5 (mvnz R4,R5) -> Done=1, R4 stays 7.
  - After an add that leaves G=3: same instruction -> R4=9.
- Reset and Run mid-operation:
  - Assert Reset during T2 of add R0,R1 -> R0 is never written; state returns to T0.
  - Toggle Run during T1..T3 of an ALU op -> no extra instruction is fetched.
